// File: rtl/sram_reqresp_rw_if.sv
// Request/response bus for sram_reqresp_rw: the master issues read/write requests and consumes
// responses; the slave (the SRAM) accepts requests and returns responses in order.
interface sram_reqresp_rw_if #(
  parameter int P_DATA_NBITS  = 32,
  parameter int P_NUM_ENTRIES = 128
);
  localparam int c_addr_nbits = $clog2(P_NUM_ENTRIES);
  localparam int c_mask_nbits = P_DATA_NBITS / 8;

  logic                    req_val;
  logic                    req_rdy;
  logic                    req_type;
  logic [c_addr_nbits-1:0] req_addr;
  logic [c_mask_nbits-1:0] req_wmask;
  logic [P_DATA_NBITS-1:0] req_data;
  logic                    resp_val;
  logic                    resp_rdy;
  logic                    resp_type;
  logic [P_DATA_NBITS-1:0] resp_data;

  modport master (
    output req_val, req_type, req_addr, req_wmask, req_data, resp_rdy,
    input  req_rdy, resp_val, resp_type, resp_data
  );

  modport slave (
    input  req_val, req_type, req_addr, req_wmask, req_data, resp_rdy,
    output req_rdy, resp_val, resp_type, resp_data
  );
endinterface

// File: rtl/sram_reqresp_rw.sv
// Single-port SRAM with val/rdy request/response; 2-cycle min latency, response queue absorbs
// resp_rdy backpressure via registered req_rdy. `SRAM_INIT_EN adds a zero-fill INIT phase.
module sram_reqresp_rw #(
  parameter int P_DATA_NBITS  = 32,
  parameter int P_NUM_ENTRIES = 128,
  parameter int P_RESP_DEPTH  = 3
) (
  input logic              clk0,
  input logic              rst0_n,
  sram_reqresp_rw_if.slave bus
);
  localparam int c_addr_nbits = $clog2(P_NUM_ENTRIES);
  localparam int c_mask_nbits = P_DATA_NBITS / 8;
  localparam int c_ptr_nbits  = $clog2(P_RESP_DEPTH);
  localparam int c_occ_nbits  = $clog2(P_RESP_DEPTH + 1);
  localparam logic [c_ptr_nbits-1:0] c_ptr_last = c_ptr_nbits'(P_RESP_DEPTH - 1);
  localparam logic [c_occ_nbits:0]   c_depth    = (c_occ_nbits + 1)'(P_RESP_DEPTH);

  typedef struct packed {
    logic                    typ;
    logic [P_DATA_NBITS-1:0] data;
  } resp_t;

`ifdef SRAM_INIT_EN
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  localparam state_e c_reset_state = ST_INIT;
  localparam logic [c_addr_nbits-1:0] c_addr_last = c_addr_nbits'(P_NUM_ENTRIES - 1);
  logic [c_addr_nbits-1:0] init_addr_q, init_addr_d;
`else
  typedef enum logic {ST_RUN = 1'b0} state_e;
  localparam state_e c_reset_state = ST_RUN;
`endif

  logic [P_DATA_NBITS-1:0] mem   [P_NUM_ENTRIES];
  resp_t                   q_mem [P_RESP_DEPTH];

  state_e                  state_q, state_d;
  logic                    rdy_q, rdy_d;
  logic                    infl_q, infl_d;
  logic                    infl_type_q, infl_type_d;
  logic [P_DATA_NBITS-1:0] rdata_q;
  logic [c_ptr_nbits-1:0]  head_q, head_d, tail_q, tail_d;
  logic [c_occ_nbits-1:0]  occ_q, occ_d;
  logic [c_occ_nbits:0]    reserved_d;
  logic                    accept, enq, deq;
  resp_t                   head_ent;

  function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] p);
    return (p == c_ptr_last) ? '0 : p + 1'b1;
  endfunction

  assign accept = bus.req_val && rdy_q;
  assign enq    = infl_q;
  assign deq    = (occ_q != '0) && bus.resp_rdy;

  always_comb begin
    state_d     = state_q;
    infl_d      = accept;
    infl_type_d = accept ? bus.req_type : infl_type_q;
    head_d      = deq ? ptr_inc(head_q) : head_q;
    tail_d      = enq ? ptr_inc(tail_q) : tail_q;
    occ_d       = occ_q;
    if (enq && !deq) begin
      occ_d = occ_q + 1'b1;
    end else if (!enq && deq) begin
      occ_d = occ_q - 1'b1;
    end
`ifdef SRAM_INIT_EN
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + 1'b1;
      if (init_addr_q == c_addr_last) begin
        state_d = ST_RUN;
      end
    end
`endif
    // A slot is reserved for every in-flight access so the queue can never overflow.
    reserved_d = {1'b0, occ_d} + {{c_occ_nbits{1'b0}}, infl_d};
    rdy_d      = (state_d == ST_RUN) && (reserved_d < c_depth);
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q     <= c_reset_state;
      rdy_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_type_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
`ifdef SRAM_INIT_EN
      init_addr_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      infl_q      <= infl_d;
      infl_type_q <= infl_type_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
`ifdef SRAM_INIT_EN
      init_addr_q <= init_addr_d;
`endif
    end
  end

  // Storage and queue payload carry no reset; only the control state above does.
  always_ff @(posedge clk0) begin
    if (accept) begin
      if (bus.req_type) begin
        for (int i = 0; i < c_mask_nbits; i++) begin
          if (bus.req_wmask[i]) begin
            mem[bus.req_addr][8*i +: 8] <= bus.req_data[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem[bus.req_addr];
      end
    end
`ifdef SRAM_INIT_EN
    if (state_q == ST_INIT) begin
      mem[init_addr_q] <= '0;
    end
`endif
    if (enq) begin
      q_mem[tail_q] <= '{typ: infl_type_q, data: infl_type_q ? '0 : rdata_q};
    end
  end

  assign head_ent      = q_mem[head_q];
  assign bus.req_rdy   = rdy_q;
  assign bus.resp_val  = (occ_q != '0);
  assign bus.resp_type = bus.resp_val && head_ent.typ;
  assign bus.resp_data = bus.resp_val ? head_ent.data : '0;
endmodule

// File: tb/tb_sram_reqresp_rw.sv
// Self-checking bench for sram_reqresp_rw: directed steps plus a randomized phase, checked
// against a word-array memory model and an in-order expected-response queue.
module tb_sram_reqresp_rw;
  localparam int DW = 32;
  localparam int NE = 128;
  localparam int RD = 3;

  logic clk0   = 1'b0;
  logic rst0_n = 1'b0;
  always #5 clk0 = ~clk0;

  sram_reqresp_rw_if #(.P_DATA_NBITS(DW), .P_NUM_ENTRIES(NE)) bus ();

  sram_reqresp_rw #(.P_DATA_NBITS(DW), .P_NUM_ENTRIES(NE), .P_RESP_DEPTH(RD)) dut (
    .clk0   (clk0),
    .rst0_n (rst0_n),
    .bus    (bus)
  );

  typedef struct {
    logic          typ;
    logic [DW-1:0] data;
    int            acc;
  } exp_t;

  int            errors = 0;
  int            checks = 0;
  int            cyc    = 0;
  int            n_acc  = 0;
  int            stalls = 0;
  bit            chk_lat = 1'b0;
  logic [DW-1:0] last_rd = '0;
  logic [DW-1:0] model [NE];
  exp_t          expq [$];

  always @(posedge clk0) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Observe both handshakes half a cycle before the edge that commits them.
  always @(negedge clk0) begin
    exp_t e;
    if (rst0_n) begin
      if (bus.resp_val && bus.resp_rdy) begin
        chk("resp_expected", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("resp_type", 64'(bus.resp_type), 64'(e.typ));
          chk("resp_data", 64'(bus.resp_data), 64'(e.data));
          if (chk_lat) chk("resp_latency", 64'(cyc + 1 - e.acc), 64'd2);
          if (!bus.resp_type) last_rd = bus.resp_data;
        end
      end
      if (bus.req_val && bus.req_rdy) begin
        e.typ = bus.req_type;
        e.acc = cyc + 1;
        if (bus.req_type) begin
          for (int b = 0; b < DW / 8; b++)
            if (bus.req_wmask[b]) model[bus.req_addr][8*b +: 8] = bus.req_data[8*b +: 8];
          e.data = '0;
        end else begin
          e.data = model[bus.req_addr];
        end
        expq.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic req(input logic t, input int a, input logic [3:0] m, input logic [DW-1:0] d);
    int w = 0;
    bus.req_val   = 1'b1;
    bus.req_type  = t;
    bus.req_addr  = 7'(a);
    bus.req_wmask = m;
    bus.req_data  = d;
    @(negedge clk0);
    while (!bus.req_rdy && w < 200) begin
      @(posedge clk0); #1;
      bus.resp_rdy = 1'b1;
      w++;
      stalls++;
      @(negedge clk0);
    end
    chk("req_accepted", 64'(bus.req_rdy), 64'd1);
    @(posedge clk0); #1;
  endtask

  task automatic idle();
    bus.req_val = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    bus.req_val  = 1'b0;
    bus.resp_rdy = 1'b1;
    while (expq.size() != 0 && w < 100) begin
      @(posedge clk0); #1;
      w++;
    end
    chk("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!bus.req_rdy && n < 1000) begin
      @(posedge clk0); #1;
      n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            n;
    int            base;
    logic          s_type;
    logic [DW-1:0] s_data;

    bus.req_val   = 1'b0;
    bus.req_type  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wmask = '0;
    bus.req_data  = '0;
    bus.resp_rdy  = 1'b1;
    repeat (3) @(posedge clk0);
    #1;
    chk("rst_req_rdy",   64'(bus.req_rdy),   64'd0);
    chk("rst_resp_val",  64'(bus.resp_val),  64'd0);
    chk("rst_resp_type", 64'(bus.resp_type), 64'd0);
    chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
    rst0_n = 1'b1;
    wait_rdy(n);
`ifdef SRAM_INIT_EN
    chk("rdy_after_init", 64'(n), 64'(NE));
    for (int i = 0; i < NE; i++) model[i] = '0;
    chk_lat = 1'b1;
    req(1'b0, 0, 4'h0, '0);
    req(1'b0, NE - 1, 4'h0, '0);
    for (int i = 0; i < 6; i++) req(1'b0, $urandom_range(0, NE - 1), 4'h0, '0);
    drain();
    chk("init_read_zero", 64'(last_rd), 64'd0);
`else
    chk("rdy_after_reset", 64'(n), 64'd1);
`endif

    // Give every word a known value so any later read has a defined expectation.
    chk_lat = 1'b1;
    for (int i = 0; i < NE; i++) req(1'b1, i, 4'hF, $urandom);
    drain();

    req(1'b1, 5, 4'hF, 32'hDEADBEEF);
    req(1'b0, 5, 4'h0, '0);
    drain();
    chk("t1_read", 64'(last_rd), 64'hDEADBEEF);
    req(1'b1, 5, 4'h0, 32'h12345678);
    req(1'b0, 5, 4'h0, '0);
    drain();
    chk("zero_mask_read", 64'(last_rd), 64'hDEADBEEF);

    req(1'b1, 9, 4'hF, 32'h11223344);
    req(1'b1, 9, 4'h5, 32'hAABBCCDD);
    req(1'b0, 9, 4'h0, '0);
    drain();
    chk("t2_masked_read", 64'(last_rd), 64'h11BB33DD);

    stalls = 0;
    base   = n_acc;
    for (int i = 0; i < 16; i++) req(1'b0, i, 4'h0, '0);
    idle();
    drain();
    chk("t3_no_stall", 64'(stalls), 64'd0);
    chk("t3_accepts",  64'(n_acc - base), 64'd16);

    chk_lat      = 1'b0;
    bus.resp_rdy = 1'b0;
    base         = n_acc;
    bus.req_val  = 1'b1;
    bus.req_type = 1'b0;
    bus.req_addr = 7'd20;
    repeat (8) begin
      @(posedge clk0); #1;
      bus.req_addr = bus.req_addr + 7'd1;
    end
    chk("t4_accepts",  64'(n_acc - base), 64'(RD));
    chk("t4_rdy_low",  64'(bus.req_rdy),  64'd0);
    chk("t4_resp_val", 64'(bus.resp_val), 64'd1);
    s_type = bus.resp_type;
    s_data = bus.resp_data;
    repeat (3) @(posedge clk0);
    #1;
    chk("t4_hold_type", 64'(bus.resp_type), 64'(s_type));
    chk("t4_hold_data", 64'(bus.resp_data), 64'(s_data));
    drain();

    for (int i = 0; i < 300; i++) begin
      bus.resp_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        idle();
        @(posedge clk0); #1;
      end
      req(1'($urandom_range(0, 1)), $urandom_range(0, NE - 1), 4'($urandom), $urandom);
    end
    drain();

    bus.resp_rdy = 1'b0;
    req(1'b0, 1, 4'h0, '0);
    req(1'b0, 2, 4'h0, '0);
    idle();
    repeat (3) @(posedge clk0);
    #1;
    chk("t5_queued", 64'(bus.resp_val), 64'd1);
    #2;
    rst0_n = 1'b0;
    #1;
    chk("t5_async_resp_val",  64'(bus.resp_val),  64'd0);
    chk("t5_async_resp_data", 64'(bus.resp_data), 64'd0);
    chk("t5_async_req_rdy",   64'(bus.req_rdy),   64'd0);
    expq.delete();
    repeat (2) @(posedge clk0);
    #1;
    rst0_n       = 1'b1;
    bus.resp_rdy = 1'b1;
    @(posedge clk0); #1;
    chk("t5_queue_empty", 64'(bus.resp_val), 64'd0);
    wait_rdy(n);
`ifdef SRAM_INIT_EN
    for (int i = 0; i < NE; i++) model[i] = '0;
    req(1'b0, 9, 4'h0, '0);
    drain();
    chk("t5_reinit_zero", 64'(last_rd), 64'd0);
`endif
    chk("t5_rdy_back", 64'(bus.req_rdy), 64'd1);
    req(1'b1, 3, 4'hF, 32'hCAFEF00D);
    req(1'b0, 3, 4'h0, '0);
    drain();
    chk("t5_post_reset_read", 64'(last_rd), 64'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
